// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if : core-side request/response bundle of the LSU. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit : RV32I load/store to word-addressed memory with timeout. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  load_store_unit_if.slave    bus,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [31:0]         mem_addr_o,
  output logic [3:0]          mem_be_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_ack_i,
  input  logic [31:0]         mem_rdata_i
);

  localparam int             CW     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0]  C_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   maddr_q, maddr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   mwdata_q, mwdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          w_legal;
  logic          w_aligned;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_load;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;

  // funct3[1:0] encodes access size for both loads and stores
  always_comb begin
    w_legal   = 1'b0;
    w_aligned = 1'b0;
    w_be      = 4'b0000;
    w_wdata   = 32'd0;
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !bus.req_we;
      default:                w_legal = 1'b0;
    endcase
    case (bus.req_funct3[1:0])
      2'b00: begin
        w_aligned = 1'b1;
        w_be      = 4'b0001 << bus.req_addr[1:0];
        w_wdata   = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_aligned = !bus.req_addr[0];
        w_be      = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata   = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        w_aligned = (bus.req_addr[1:0] == 2'b00);
        w_be      = 4'b1111;
        w_wdata   = bus.req_wdata;
      end
      default: begin
        w_aligned = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_byte = mem_rdata_i[8*off_q +: 8];
    w_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (f3_q)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    f3_d     = f3_q;
    off_d    = off_q;
    maddr_d  = maddr_q;
    be_d     = be_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_legal && w_aligned) begin
            state_d  = S_ACCESS;
            we_d     = bus.req_we;
            f3_d     = bus.req_funct3;
            off_d    = bus.req_addr[1:0];
            maddr_d  = {bus.req_addr[31:2], 2'b00};
            be_d     = w_be;
            mwdata_d = bus.req_we ? w_wdata : 32'd0;
            cnt_d    = '0;
          end else begin
            state_d = S_DONE;
            rdata_d = 32'd0;
            err_d   = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack_i) begin
          state_d = S_DONE;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : w_load;
        end else if (cnt_q == C_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      f3_q     <= 3'd0;
      off_q    <= 2'd0;
      maddr_q  <= 32'd0;
      be_q     <= 4'd0;
      mwdata_q <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      off_q    <= off_d;
      maddr_q  <= maddr_d;
      be_q     <= be_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign mem_req_o     = (state_q == S_ACCESS);
  assign mem_we_o      = we_q;
  assign mem_addr_o    = maddr_q;
  assign mem_be_o      = be_q;
  assign mem_wdata_o   = mwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit : directed table, random model-checked ops, reset abort. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_load_store_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_err    = 0;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_be_o    (mem_be),
    .mem_wdata_o (mem_wdata),
    .mem_ack_i   (mem_ack),
    .mem_rdata_i (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] word;
    int          ack_n;   // ACCESS cycle (1-based) with ack; 0 = never
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] mwdata;
    int          mreq;    // expected mem_req cycles
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: works from access size in bytes and plain arithmetic
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int size, sh;
    bit legal;
    longint unsigned val, msk;
    sh    = int'(v.addr[1:0]);
    legal = v.we ? (v.f3 <= 3'd2) : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << v.f3[1:0];
    r.be = 4'd0; r.mwdata = 32'd0;
    if (!legal || (sh % size) != 0) begin
      r.err = 1'b1; r.rdata = 32'd0; r.mreq = 0;
      return r;
    end
    r.be = 4'(((1 << size) - 1) << sh);
    if (v.we)
      for (int l = 0; l < 4; l++) r.mwdata[8*l +: 8] = v.wdata[8*(l % size) +: 8];
    if (v.ack_n == 0 || v.ack_n > TO) begin
      r.err = 1'b1; r.rdata = 32'd0; r.mreq = TO;
    end else begin
      r.err = 1'b0; r.mreq = v.ack_n;
      if (v.we) r.rdata = 32'd0;
      else begin
        msk = (64'd1 << (8 * size)) - 1;
        val = (longint'(v.word) >> (8 * sh)) & msk;
        if (!v.f3[2] && size < 4 && val[8*size-1]) val = val - (64'd1 << (8 * size));
        r.rdata = val[31:0];
      end
    end
    return r;
  endfunction

  task automatic run_op(input vec_t e, input string tag);
    int w, mreq, lat;
    bit got, stable;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = e.we;
    bus.req_funct3 = e.f3;
    bus.req_addr   = e.addr;
    bus.req_wdata  = e.wdata;
    w = 0;
    while (!bus.req_ready && w < 10) begin @(negedge clk); w++; end
    chk({tag, " ready"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    mreq = 0; lat = 0; got = 0; stable = 1; rd = 0; er = 0;
    for (int c = 1; c <= TO + 4 && !got; c++) begin
      if (bus.rsp_valid) begin
        got = 1; lat = c; rd = bus.rsp_rdata; er = bus.rsp_err;
        if (bus.req_ready) stable = 0;
      end
      if (mem_req) begin
        mreq++;
        if (mem_we !== e.we || mem_addr !== (e.addr & 32'hFFFF_FFFC) ||
            mem_be !== e.be || mem_wdata !== e.mwdata) stable = 0;
        mem_ack   = (mreq == e.ack_n);
        mem_rdata = (mreq == e.ack_n) ? e.word : $urandom;
      end else begin
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
      if (!got) begin @(posedge clk); #1; end
    end
    mem_ack = 1'b0;
    chk({tag, " rsp_seen"}, 32'(got), 32'd1);
    chk({tag, " latency"}, 32'(lat), 32'(e.mreq + 1));
    chk({tag, " mreq_cycles"}, 32'(mreq), 32'(e.mreq));
    chk({tag, " mem_sigs"}, 32'(stable), 32'd1);
    chk({tag, " rdata"}, rd, e.rdata);
    chk({tag, " err"}, 32'(er), 32'(e.err));
    @(posedge clk); #1;
    chk({tag, " pulse_end"}, {30'd0, bus.rsp_valid, bus.req_ready}, 32'd1);
    chk({tag, " hold"}, bus.rsp_rdata, e.rdata);
  endtask

  vec_t tbl[13];
  vec_t rv;

  initial begin
    bus.req_valid = 0; bus.req_we = 0; bus.req_funct3 = 0;
    bus.req_addr = 0; bus.req_wdata = 0;
    mem_ack = 0; mem_rdata = 0;

    //          we  f3     addr           wdata          word          ack err rdata          be       mwdata      mreq
    tbl[0]  = '{0, 3'b010, 32'h0000_0010, 32'h0,         32'hDEADBEEF, 1,  0, 32'hDEADBEEF, 4'b1111, 32'h0,        1};
    tbl[1]  = '{0, 3'b000, 32'h0000_0103, 32'h0,         32'h80FF1234, 1,  0, 32'hFFFFFF80, 4'b1000, 32'h0,        1};
    tbl[2]  = '{0, 3'b100, 32'h0000_0103, 32'h0,         32'h80FF1234, 2,  0, 32'h00000080, 4'b1000, 32'h0,        2};
    tbl[3]  = '{0, 3'b001, 32'h0000_0102, 32'h0,         32'h80FF1234, 1,  0, 32'hFFFF80FF, 4'b1100, 32'h0,        1};
    tbl[4]  = '{0, 3'b101, 32'h0000_0102, 32'h0,         32'h80FF1234, 1,  0, 32'h000080FF, 4'b1100, 32'h0,        1};
    tbl[5]  = '{1, 3'b001, 32'h0000_0102, 32'h1234BEEF,  32'h0,        3,  0, 32'h0,        4'b1100, 32'hBEEFBEEF, 3};
    tbl[6]  = '{0, 3'b010, 32'h0000_0101, 32'h0,         32'h0,        1,  1, 32'h0,        4'b0000, 32'h0,        0};
    tbl[7]  = '{0, 3'b011, 32'h0000_0000, 32'h0,         32'h0,        1,  1, 32'h0,        4'b0000, 32'h0,        0};
    tbl[8]  = '{0, 3'b010, 32'h0000_0200, 32'h0,         32'h11223344, 0,  1, 32'h0,        4'b1111, 32'h0,        16};
    tbl[9]  = '{0, 3'b010, 32'h0000_0200, 32'h0,         32'h11223344, 16, 0, 32'h11223344, 4'b1111, 32'h0,        16};
    tbl[10] = '{1, 3'b000, 32'h0000_0001, 32'h000000A5,  32'h0,        2,  0, 32'h0,        4'b0010, 32'hA5A5A5A5, 2};
    tbl[11] = '{1, 3'b100, 32'h0000_0000, 32'h0,         32'h0,        1,  1, 32'h0,        4'b0000, 32'h0,        0};
    tbl[12] = '{0, 3'b001, 32'h0000_0101, 32'h0,         32'h0,        1,  1, 32'h0,        4'b0000, 32'h0,        0};

    repeat (2) @(negedge clk);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset outs", {mem_addr | mem_wdata | bus.rsp_rdata}, 32'd0);
    chk("reset be_we_err", {27'd0, mem_be, mem_we ^ bus.rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      rv.we    = 1'($urandom_range(0, 1));
      rv.f3    = 3'($urandom_range(0, 7));
      rv.addr  = $urandom;
      rv.wdata = $urandom;
      rv.word  = $urandom;
      rv.ack_n = $urandom_range(0, 18);
      run_op(model(rv), $sformatf("rnd%0d", i));
    end

    // Reset in the second ACCESS cycle aborts the request silently
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h40;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort mem_req_before", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("abort mem_req_async", 32'(mem_req), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    chk("abort ready", 32'(bus.req_ready), 32'd1);
    begin
      bit seen = 0;
      for (int c = 0; c < 6; c++) begin
        mem_ack = 1'b1;
        @(posedge clk); #1;
        if (bus.rsp_valid || mem_req) seen = 1;
      end
      mem_ack = 1'b0;
      chk("abort no_rsp", 32'(seen), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

`default_nettype wire
